// File: rtl/da4_pkg.sv
// rtl/da4_pkg.sv - shared constants and state encoding for the DA4 update scheduler
package da4_pkg;
  localparam logic [3:0] CMD_WR_UPD    = 4'b0011;
  localparam logic [3:0] CMD_REF_SETUP = 4'b1000;
  localparam int         REF_ON        = 1;

  typedef enum logic [2:0] {
    ST_INIT_SEND,
    ST_INIT_WAIT,
    ST_GAP,
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin first-set finder over request bits, starting after last
module rr_pick #(
  parameter int NCH = 8
) (
  input  logic [NCH-1:0] req,
  input  logic [2:0]     last,
  output logic           found,
  output logic [2:0]     idx
);
  // Walk from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    logic [2:0] k;
    found = 1'b0;
    idx   = last;
    k     = '0;
    for (int i = NCH; i >= 1; i--) begin
      k = 3'((int'(last) + i) % NCH);
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end
endmodule

// File: rtl/da4_update_scheduler.sv
// rtl/da4_update_scheduler.sv - sequences reference-enable and per-channel writes to the DA4 SPI master
module da4_update_scheduler #(
  parameter int NCH     = 8,
  parameter int DW      = 12,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk100mhz,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [2:0]    wr_ch,
  input  logic [DW-1:0] wr_data,
  output logic          st_wrt,
  output logic [3:0]    dac_cmd,
  output logic [3:0]    dac_addr,
  output logic [DW-1:0] dac_data,
  input  logic          done,
  output logic          init_done,
  output logic          busy,
  output logic          err
);
  import da4_pkg::*;

  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      ch, ch_n, last_ch;
  logic [NCH-1:0]  dirty, wr_mask, clr_mask, pick_req;
  logic [DW-1:0]   shadow [NCH];
  logic            pick_found;
  logic [2:0]      pick_idx;
  logic            start, load_init, load_ch, set_init, set_err;

  always_comb begin
    wr_mask = '0;
    if (wr_en && ({29'd0, wr_ch} < NCH)) wr_mask[wr_ch] = 1'b1;
  end

  // A write landing this cycle is visible to the picker so IDLE can leave immediately.
  assign pick_req = dirty | wr_mask;

  rr_pick #(.NCH(NCH)) u_pick (
    .req   (pick_req),
    .last  (last_ch),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ch_n      = ch;
    start     = 1'b0;
    load_init = 1'b0;
    load_ch   = 1'b0;
    set_init  = 1'b0;
    set_err   = 1'b0;
    clr_mask  = '0;
    case (state)
      ST_INIT_SEND: begin
        start     = 1'b1;
        load_init = 1'b1;
        cnt_n     = '0;
        state_n   = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (done) begin
          set_init = 1'b1;
          cnt_n    = '0;
          state_n  = ST_GAP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          set_init = 1'b1;
          set_err  = 1'b1;
          cnt_n    = '0;
          state_n  = ST_GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pick_found) begin
          ch_n    = pick_idx;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        start        = 1'b1;
        load_ch      = 1'b1;
        clr_mask[ch] = 1'b1;
        cnt_n        = '0;
        state_n      = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          cnt_n   = '0;
          state_n = ST_GAP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          set_err = 1'b1;
          cnt_n   = '0;
          state_n = ST_GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_INIT_SEND;
    endcase
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT_SEND;
      cnt       <= '0;
      ch        <= '0;
      last_ch   <= 3'(NCH - 1);
      st_wrt    <= 1'b0;
      dac_cmd   <= '0;
      dac_addr  <= '0;
      dac_data  <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ch        <= ch_n;
      st_wrt    <= start;
      init_done <= init_done | set_init;
      err       <= err | set_err;
      if (load_init) begin
        dac_cmd  <= CMD_REF_SETUP;
        dac_addr <= 4'h0;
        dac_data <= DW'(REF_ON);
      end
      if (load_ch) begin
        dac_cmd  <= CMD_WR_UPD;
        dac_addr <= {1'b0, ch};
        dac_data <= shadow[ch];
        last_ch  <= ch;
      end
    end
  end

  // Set beats clear so a write racing its own SEND is re-sent with the new value.
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= '0;
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
    end else begin
      dirty <= (dirty & ~clr_mask) | wr_mask;
      for (int i = 0; i < NCH; i++) begin
        if (wr_mask[i]) shadow[i] <= wr_data;
      end
    end
  end

  assign busy = (state == ST_SEND) || (state == ST_WAIT);
endmodule

// File: tb/tb_da4_update_scheduler.sv
// tb/tb_da4_update_scheduler.sv - scoreboard bench with a responding SPI master model
module tb_da4_update_scheduler;
  localparam int NCH     = 8;
  localparam int DW      = 12;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 4096;

  typedef struct {
    logic [3:0]    cmd;
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } xfer_t;

  logic          clk, rst_n, wr_en, done, st_wrt, init_done, busy, err;
  logic          resp_done, stray_done, withhold, st_prev;
  logic [2:0]    wr_ch;
  logic [DW-1:0] wr_data, dac_data;
  logic [3:0]    dac_cmd, dac_addr;
  int            vectors, miscompares, cyc, done_cyc;
  xfer_t         exp_q[$];

  assign done = resp_done | stray_done;

  da4_update_scheduler #(.NCH(NCH), .DW(DW), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk100mhz (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .st_wrt    (st_wrt),
    .dac_cmd   (dac_cmd),
    .dac_addr  (dac_addr),
    .dac_data  (dac_data),
    .done      (done),
    .init_done (init_done),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] cmd, input logic [3:0] addr, input logic [DW-1:0] data);
    xfer_t x;
    x.cmd = cmd; x.addr = addr; x.data = data;
    exp_q.push_back(x);
  endtask

  // Caller sits at a negedge; back-to-back calls give writes in consecutive cycles.
  task automatic wr(input logic [2:0] ch, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_ch = ch; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("quiet_bound", 32'(n < budget), 32'd1);
    repeat (GAP + 4) @(negedge clk);
  endtask

  // Monitor: every start pulse pops one expected transfer.
  initial begin
    xfer_t e;
    st_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && st_wrt) begin
        chk("st_wrt_width", 32'(st_prev), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_st_wrt", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_cmd", 32'(dac_cmd), 32'(e.cmd));
          chk("xfer_addr", 32'(dac_addr), 32'(e.addr));
          chk("xfer_data", 32'(dac_data), 32'(e.data));
          chk("cs_gap", 32'((cyc - done_cyc) >= GAP + 2), 32'd1);
        end
      end
      st_prev = st_wrt & rst_n;
    end
  end

  // SPI master model: done 20 cycles after each start unless withheld.
  initial begin
    logic [3:0] c_cmd, c_addr;
    logic [DW-1:0] c_data;
    bit ok;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && st_wrt && !withhold) begin
        c_cmd = dac_cmd; c_addr = dac_addr; c_data = dac_data;
        ok = 1'b1;
        for (int i = 0; i < 19; i++) begin
          @(negedge clk);
          if (!rst_n) ok = 1'b0;
        end
        if (ok) begin
          resp_done = 1'b1;
          done_cyc  = cyc;
          chk("busy_at_done", 32'(busy), 32'(c_cmd == 4'b0011));
          chk("stable_at_done", {dac_cmd, dac_addr, 12'(dac_data)}, {c_cmd, c_addr, 12'(c_data)});
          @(negedge clk);
          resp_done = 1'b0;
          chk("stable_after_done", {dac_cmd, dac_addr, 12'(dac_data)}, {c_cmd, c_addr, 12'(c_data)});
        end
      end
    end
  end

  initial begin
    int n;
    vectors = 0; miscompares = 0; cyc = 0; done_cyc = -1000;
    rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    stray_done = 1'b0; withhold = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_st_wrt", 32'(st_wrt), 32'd0);
    chk("rst_cmd", 32'(dac_cmd), 32'd0);
    chk("rst_addr", 32'(dac_addr), 32'd0);
    chk("rst_data", 32'(dac_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    push(4'b1000, 4'h0, 12'h001);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_st_wrt_latency", 32'(st_wrt), 32'd1);
    n = 0;
    while (!init_done && n < 100) begin @(negedge clk); n++; end
    chk("init_done", 32'(init_done), 32'd1);
    wait_quiet(500);
    repeat (30) @(negedge clk);
    chk("init_no_err", 32'(err), 32'd0);

    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("stray_done_busy", 32'(busy), 32'd0);
    chk("stray_done_err", 32'(err), 32'd0);

    push(4'b0011, 4'h3, 12'hABC);
    wr(3'd3, 12'hABC);
    chk("send_busy", 32'(busy), 32'd1);
    chk("send_no_st_wrt_yet", 32'(st_wrt), 32'd0);
    @(negedge clk);
    chk("wr_latency", 32'(st_wrt), 32'd1);
    wait_quiet(500);

    push(4'b0011, 4'h0, 12'h111);
    push(4'b0011, 4'h2, 12'h200);
    wr(3'd0, 12'h111);
    repeat (5) @(negedge clk);
    wr(3'd2, 12'h100);
    repeat (3) @(negedge clk);
    wr(3'd2, 12'h200);
    wait_quiet(500);

    push(4'b0011, 4'h4, 12'h444);
    push(4'b0011, 4'h4, 12'h555);
    wr(3'd4, 12'h444);
    wr(3'd4, 12'h555);
    wait_quiet(500);

    withhold = 1'b1;
    push(4'b0011, 4'h7, 12'h777);
    wr(3'd7, 12'h777);
    repeat (5) @(negedge clk);
    push(4'b0011, 4'h6, 12'h666);
    wr(3'd6, 12'h666);
    n = 0;
    while (!err && n < TIMEOUT + 100) begin @(negedge clk); n++; end
    chk("timeout_err", 32'(err), 32'd1);
    withhold = 1'b0;
    wait_quiet(500);
    chk("err_sticky", 32'(err), 32'd1);

    withhold = 1'b1;
    push(4'b0011, 4'h1, 12'h123);
    wr(3'd1, 12'h123);
    repeat (10) @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_st_wrt", 32'(st_wrt), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_data", 32'(dac_data), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    @(negedge clk);
    withhold = 1'b0;
    chk("queue_drained", exp_q.size(), 32'd0);
    push(4'b1000, 4'h0, 12'h001);
    push(4'b0011, 4'h1, 12'h015);
    push(4'b0011, 4'h5, 12'h055);
    push(4'b0011, 4'h6, 12'h066);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_ref", 32'(st_wrt), 32'd1);
    @(negedge clk);
    wr(3'd5, 12'h055);
    wr(3'd1, 12'h015);
    wr(3'd6, 12'h066);
    wait_quiet(800);
    repeat (10) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
